// File: rtl/keypad_lock_ctrl.sv
// Keypad password lock: BCD digit entry, compare, try limit with timed lockout, tone buzzer.
// All outputs are registered and update on the edge that samples the key press; there is no backpressure.
module keypad_lock_ctrl #(
  parameter int unsigned         DIGITS      = 3,
  parameter logic [4*DIGITS-1:0] PASSWORD    = 12'h246,
  parameter int unsigned         MAX_TRIES   = 3,
  parameter int unsigned         LOCK_SECS   = 20,
  parameter int unsigned         TICK_CYCLES = 50_000_000,
  parameter int unsigned         CLICK_HP    = 50_000,
  parameter int unsigned         CLICK_LEN   = 10_000_000,
  parameter int unsigned         OK_HP       = 25_000,
  parameter int unsigned         OK_LEN      = 30_000_000,
  parameter int unsigned         FAIL_HP     = 100_000,
  parameter int unsigned         FAIL_LEN    = 15_000_000
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [15:0]           key_onehot,
  output logic [4*DIGITS-1:0]   display,
  output logic [3:0]            digit_count,
  output logic [3:0]            tries,
  output logic [1:0]            state,
  output logic                  buzzer
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0]  BLANK      = '1;
  localparam logic [W-1:0]  TOP_F      = ~(BLANK >> 4);
  localparam logic [W-1:0]  OPEN_GLYPH = {DIGITS{4'hA}};
  localparam logic [31:0]   GATE_LO    = 32'(FAIL_LEN / 3);
  localparam logic [31:0]   GATE_HI    = 32'(2 * FAIL_LEN / 3);

  typedef enum logic [1:0] {ST_ENTRY = 2'd0, ST_OPEN = 2'd1, ST_LOCK = 2'd2} state_t;
  typedef enum logic [1:0] {T_NONE, T_CLICK, T_OK, T_FAIL} tone_t;

  state_t        state_q, state_n;
  logic [15:0]   key_prev;
  logic [W-1:0]  disp_q;
  logic [3:0]    cnt_q, tries_q;
  logic [6:0]    remaining_q;
  logic [31:0]   tick_cnt;
  tone_t         tone_q;
  logic [31:0]   dur_q, hp_q, tone_hp, tone_len;
  logic          buzz_q;

  logic          is_digit, is_enter, is_bs, is_clr, is_rall;
  logic [3:0]    digit_val;
  logic          press, ev_digit, ev_enter, ev_bs, ev_clr, ev_rall;
  logic          in_entry, full, match, tick, last_try;
  logic          good_enter, bad_enter, click;
  logic [W+3:0]  lock_view;

  // Exact-value decode: multi-bit codes and the unused bits fall into default.
  always_comb begin
    is_digit  = 1'b0;
    is_enter  = 1'b0;
    is_bs     = 1'b0;
    is_clr    = 1'b0;
    is_rall   = 1'b0;
    digit_val = 4'd0;
    case (key_onehot)
      16'h0008: begin is_digit = 1'b1; digit_val = 4'd0; end
      16'h0080: begin is_digit = 1'b1; digit_val = 4'd1; end
      16'h0040: begin is_digit = 1'b1; digit_val = 4'd2; end
      16'h0020: begin is_digit = 1'b1; digit_val = 4'd3; end
      16'h0800: begin is_digit = 1'b1; digit_val = 4'd4; end
      16'h0400: begin is_digit = 1'b1; digit_val = 4'd5; end
      16'h0200: begin is_digit = 1'b1; digit_val = 4'd6; end
      16'h8000: begin is_digit = 1'b1; digit_val = 4'd7; end
      16'h4000: begin is_digit = 1'b1; digit_val = 4'd8; end
      16'h2000: begin is_digit = 1'b1; digit_val = 4'd9; end
      16'h0001: is_enter = 1'b1;
      16'h0010: is_bs    = 1'b1;
      16'h1000: is_clr   = 1'b1;
      16'h0100: is_rall  = 1'b1;
      default: ;
    endcase
  end

  assign press      = (key_prev == 16'h0000);
  assign ev_digit   = press & is_digit;
  assign ev_enter   = press & is_enter;
  assign ev_bs      = press & is_bs;
  assign ev_clr     = press & is_clr;
  assign ev_rall    = press & is_rall;
  assign in_entry   = (state_q == ST_ENTRY);
  assign full       = (cnt_q == 4'(DIGITS));
  assign match      = (disp_q == PASSWORD);
  assign tick       = (tick_cnt == 32'(TICK_CYCLES - 1));
  assign last_try   = ((tries_q + 4'd1) == 4'(MAX_TRIES));
  assign good_enter = in_entry & ev_enter & full & match;
  assign bad_enter  = in_entry & ev_enter & full & ~match;
  assign click      = in_entry & ev_digit;

  always_ff @(posedge clk) begin
    if (RSTn) state_q <= ST_ENTRY;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_ENTRY: begin
        if (good_enter)                 state_n = ST_OPEN;
        else if (bad_enter && last_try) state_n = ST_LOCK;
      end
      ST_OPEN:  if (ev_enter || ev_clr || ev_rall) state_n = ST_ENTRY;
      ST_LOCK:  if (tick && remaining_q == 7'd1)   state_n = ST_ENTRY;
      default:  state_n = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RSTn) begin
      key_prev    <= '0;
      disp_q      <= BLANK;
      cnt_q       <= '0;
      tries_q     <= '0;
      remaining_q <= '0;
      tick_cnt    <= '0;
    end else begin
      key_prev <= key_onehot;
      case (state_q)
        ST_ENTRY: begin
          if (ev_digit && !full) begin
            disp_q <= (disp_q << 4) | W'(digit_val);
            cnt_q  <= cnt_q + 4'd1;
          end else if (ev_bs && cnt_q != 4'd0) begin
            disp_q <= (disp_q >> 4) | TOP_F;
            cnt_q  <= cnt_q - 4'd1;
          end else if (ev_clr || ev_rall) begin
            disp_q <= BLANK;
            cnt_q  <= '0;
            if (ev_rall) tries_q <= '0;
          end else if (good_enter) begin
            disp_q  <= OPEN_GLYPH;
            cnt_q   <= '0;
            tries_q <= '0;
          end else if (bad_enter) begin
            disp_q <= BLANK;
            cnt_q  <= '0;
            if (last_try) begin
              tries_q     <= '0;
              remaining_q <= 7'(LOCK_SECS);
              tick_cnt    <= '0;
            end else begin
              tries_q <= tries_q + 4'd1;
            end
          end
        end
        ST_OPEN: begin
          if (ev_enter || ev_clr || ev_rall) disp_q <= BLANK;
        end
        ST_LOCK: begin
          if (tick) begin
            tick_cnt    <= '0;
            remaining_q <= remaining_q - 7'd1;
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (tone_q)
      T_CLICK: begin tone_hp = 32'(CLICK_HP); tone_len = 32'(CLICK_LEN); end
      T_OK:    begin tone_hp = 32'(OK_HP);    tone_len = 32'(OK_LEN);    end
      T_FAIL:  begin tone_hp = 32'(FAIL_HP);  tone_len = 32'(FAIL_LEN);  end
      default: begin tone_hp = 32'd1;         tone_len = 32'd1;          end
    endcase
  end

  // A newly requested tone always restarts the engine, preempting any tone in progress.
  always_ff @(posedge clk) begin
    if (RSTn) begin
      tone_q <= T_NONE;
      dur_q  <= '0;
      hp_q   <= '0;
      buzz_q <= 1'b0;
    end else if (bad_enter || good_enter || click) begin
      tone_q <= bad_enter ? T_FAIL : (good_enter ? T_OK : T_CLICK);
      dur_q  <= '0;
      hp_q   <= '0;
      buzz_q <= 1'b1;
    end else if (tone_q != T_NONE) begin
      if (dur_q == tone_len - 32'd1) begin
        tone_q <= T_NONE;
        dur_q  <= '0;
        hp_q   <= '0;
        buzz_q <= 1'b0;
      end else begin
        dur_q <= dur_q + 32'd1;
        if (hp_q == tone_hp - 32'd1) begin
          hp_q   <= '0;
          buzz_q <= ~buzz_q;
        end else begin
          hp_q <= hp_q + 32'd1;
        end
      end
    end
  end

  // Lockout view: remaining seconds in BCD in the low nibbles, blanks above.
  always_comb begin
    lock_view      = '1;
    lock_view[3:0] = 4'(remaining_q % 7'd10);
    if (DIGITS > 1) lock_view[7:4] = 4'(remaining_q / 7'd10);
    display     = (state_q == ST_LOCK) ? lock_view[W-1:0] : disp_q;
    digit_count = cnt_q;
    tries       = tries_q;
    state       = state_q;
    buzzer      = buzz_q & ~(tone_q == T_FAIL && dur_q > GATE_LO && dur_q < GATE_HI);
  end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Randomised and directed bench for keypad_lock_ctrl against an event-level model of the lock.
module tb_keypad_lock_ctrl;

  localparam int LOCK_SECS = 20;
  localparam int TICK      = 20;
  localparam int CLICK_LEN = 40;
  localparam int OK_LEN    = 60;
  localparam int FAIL_LEN  = 30;
  localparam int HP        = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key = 16'h0000;
  logic [11:0] display;
  logic [3:0]  digit_count, tries;
  logic [1:0]  state;
  logic        buzzer;

  keypad_lock_ctrl #(
    .DIGITS(3), .PASSWORD(12'h246), .MAX_TRIES(3), .LOCK_SECS(LOCK_SECS), .TICK_CYCLES(TICK),
    .CLICK_HP(HP), .CLICK_LEN(CLICK_LEN), .OK_HP(HP), .OK_LEN(OK_LEN),
    .FAIL_HP(HP), .FAIL_LEN(FAIL_LEN)
  ) dut (
    .clk(clk), .RSTn(rst), .key_onehot(key), .display(display), .digit_count(digit_count),
    .tries(tries), .state(state), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] K_ENTER = 16'h0001;
  localparam logic [15:0] K_BS    = 16'h0010;
  localparam logic [15:0] K_CLR   = 16'h1000;
  localparam logic [15:0] K_RALL  = 16'h0100;
  logic [15:0] dig_key [10] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800,
                                16'h0400, 16'h0200, 16'h8000, 16'h4000, 16'h2000};
  // Key index per bit: 0..9 digits, 10 ENTER, 11 BACKSPACE, 12 CLEAR, 13 RESET_ALL, -1 unused.
  int kmap [16] = '{10, -1, -1, 0, 11, 3, 2, 1, 13, 6, 5, 4, 12, 9, 8, 7};

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: entered digits as a queue, lockout and tones as start-cycle timestamps.
  bit       model_ok = 0;
  int       cyc = 0;
  int       m_state, m_tries, lock_start, tone_kind, tone_start;
  int       q[$];
  logic [15:0] m_prev;

  function automatic void start_tone(input int kind);
    tone_kind  = kind;
    tone_start = cyc;
  endfunction

  function automatic int entered_value();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  always @(posedge clk) begin
    int ev;
    cyc++;
    if (rst) begin
      model_ok = 1; m_state = 0; m_tries = 0; q.delete();
      tone_kind = 0; tone_start = 0; lock_start = 0; m_prev = 16'h0;
    end else if (model_ok) begin
      ev = -1;
      if (m_prev == 16'h0 && $countones(key) == 1)
        for (int i = 0; i < 16; i++) if (key[i]) ev = kmap[i];
      m_prev = key;
      if (m_state == 2) begin
        if (cyc - lock_start == LOCK_SECS * TICK) m_state = 0;
      end else if (m_state == 1) begin
        if (ev == 10 || ev == 12 || ev == 13) m_state = 0;
      end else if (ev >= 0 && ev <= 9) begin
        if (q.size() < 3) q.push_back(ev);
        start_tone(1);
      end else if (ev == 11) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (ev == 12 || ev == 13) begin
        q.delete();
        if (ev == 13) m_tries = 0;
      end else if (ev == 10 && q.size() == 3) begin
        if (entered_value() == 'h246) begin
          m_state = 1; m_tries = 0; start_tone(2);
        end else begin
          start_tone(3);
          if (m_tries + 1 == 3) begin
            m_state = 2; m_tries = 0; lock_start = cyc;
          end else begin
            m_tries++;
          end
        end
        q.delete();
      end
    end
  end

  function automatic logic [11:0] exp_display();
    logic [11:0] v;
    int rem;
    if (m_state == 1) return 12'hAAA;
    if (m_state == 2) begin
      rem = LOCK_SECS - (cyc - lock_start) / TICK;
      v = 12'hF00;
      v[7:4] = 4'(rem / 10);
      v[3:0] = 4'(rem % 10);
      return v;
    end
    v = 12'hFFF;
    foreach (q[i]) v = (v << 4) | 12'(q[i]);
    return v;
  endfunction

  function automatic logic exp_buzzer();
    int t, len;
    t   = cyc - tone_start;
    len = (tone_kind == 1) ? CLICK_LEN : (tone_kind == 2) ? OK_LEN : FAIL_LEN;
    if (tone_kind == 0 || t >= len) return 1'b0;
    if (tone_kind == 3 && t > FAIL_LEN / 3 && t < 2 * FAIL_LEN / 3) return 1'b0;
    return ((t / HP) % 2) == 0;
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_display", display, exp_display());
      check("model_count", digit_count, q.size());
      check("model_tries", tries, m_tries);
      check("model_state", state, m_state);
      check("model_buzzer", buzzer, exp_buzzer());
    end
  end

  task automatic press(input logic [15:0] k);
    @(negedge clk); key = k;
    @(negedge clk); key = 16'h0000;
  endtask

  task automatic enter_code(input int a, input int b, input int c);
    press(dig_key[a]); press(dig_key[b]); press(dig_key[c]); press(K_ENTER);
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clk);
    check("reset_display", display, 12'hFFF);
    check("reset_count", digit_count, 0);
    check("reset_tries", tries, 0);
    check("reset_state", state, 0);
    check("reset_buzzer", buzzer, 0);
    rst = 1'b0;

    // Correct code entry and success tone
    press(dig_key[2]); check("t1_disp1", display, 12'hFF2);
    press(dig_key[4]); check("t1_disp2", display, 12'hF24);
    press(dig_key[6]); check("t1_disp3", display, 12'h246);
    press(K_ENTER);
    check("t1_state", state, 1);
    check("t1_disp_open", display, 12'hAAA);
    check("t1_tries", tries, 0);
    check("t1_buzz_k0", buzzer, 1);
    repeat (4) @(negedge clk);
    check("t1_buzz_k4", buzzer, 0);
    repeat (60) @(negedge clk);
    check("t1_buzz_done", buzzer, 0);
    press(K_CLR);
    check("t1_back_entry", state, 0);

    // Held key and multi-bit code
    @(negedge clk); key = dig_key[5];
    repeat (10) @(negedge clk);
    key = 16'h0000;
    press(16'h0022);
    check("t2_count", digit_count, 1);
    check("t2_disp", display, 12'hFF5);
    press(K_CLR);

    // Backspace and overflow digit
    press(dig_key[7]); press(dig_key[8]); check("t4_disp78", display, 12'hF78);
    press(K_BS);       check("t4_disp_bs", display, 12'hFF7);
    press(dig_key[9]); check("t4_disp79", display, 12'hF79);
    press(dig_key[9]); check("t4_disp799", display, 12'h799);
    repeat (10) @(negedge clk);
    press(dig_key[9]);
    check("t4_overflow_disp", display, 12'h799);
    check("t4_count", digit_count, 3);
    check("t4_overflow_click", buzzer, 1);
    press(K_CLR);
    repeat (45) @(negedge clk);

    // Three wrong entries; first one checks the fail tone envelope
    enter_code(1, 2, 3);
    check("t3_tries1", tries, 1);
    check("t6_fail_k0", buzzer, 1);
    for (int i = 1; i < FAIL_LEN; i++) begin
      @(negedge clk);
      if (i == 10) check("t6_fail_k10", buzzer, 1);
      if (i == 11) check("t6_fail_k11", buzzer, 0);
      if (i == 19) check("t6_fail_k19", buzzer, 0);
      if (i == 24) check("t6_fail_k24", buzzer, 1);
    end
    enter_code(1, 2, 3);
    check("t3_tries2", tries, 2);
    enter_code(1, 2, 3);
    check("t3_lock_state", state, 2);
    check("t3_lock_disp", display, 12'hF20);
    check("t3_lock_tries", tries, 0);
    repeat (20) @(negedge clk);
    check("t3_disp_f19", display, 12'hF19);
    press(K_RALL);
    check("t3_rall_ignored", state, 2);
    repeat (377) @(negedge clk);
    check("t3_last_sec_state", state, 2);
    check("t3_last_sec_disp", display, 12'hF01);
    @(negedge clk);
    check("t3_unlock_state", state, 0);
    check("t3_unlock_disp", display, 12'hFFF);

    // Click preempts a running fail tone
    enter_code(1, 2, 3);
    repeat (5) @(negedge clk);
    press(dig_key[1]);
    check("t6_preempt_k0", buzzer, 1);
    repeat (8) @(negedge clk);
    check("t6_preempt_k8", buzzer, 1);
    repeat (40) @(negedge clk);
    press(K_CLR);

    // Short ENTER is a no-op; reset in the middle of the success tone
    press(dig_key[2]); press(dig_key[4]);
    repeat (45) @(negedge clk);
    press(K_ENTER);
    check("t5_state", state, 0);
    check("t5_tries", tries, 1);
    check("t5_count", digit_count, 2);
    check("t5_buzzer", buzzer, 0);
    press(K_CLR);
    enter_code(2, 4, 6);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_buzzer", buzzer, 0);
    check("t5_rst_disp", display, 12'hFFF);
    check("t5_rst_state", state, 0);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r == 199) begin
        rst = 1'b0;
        press(16'h0000);
        enter_code(2, 4, 6);
      end else begin
        @(negedge clk);
        rst = (r >= 196);
        if (r < 90)       key = 16'h0000;
        else if (r < 170) key = 16'h1 << $urandom_range(0, 15);
        else if (r < 185) key = 16'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0; key = 16'h0000;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
